// File: rtl/cfg_dat_test_pkg.sv
// Shared types and expected-word rule for the CFG_DAT test-mode checker.
// Define CFG_DAT_PRBS_EN to expect a PRBS16 stream instead of an increment.
package cfg_dat_test_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  localparam int WORD_CNT_W = 32;
  localparam int ERR_CNT_W  = 16;

  // x^16+x^14+x^13+x^11+1 as bit taps 15,13,12,10
  localparam logic [15:0] PRBS_TAPS = 16'hB400;

  function automatic logic [15:0] prbs_next(
    input logic [15:0] w
  );
    return {w[14:0], ^(w & PRBS_TAPS)};
  endfunction

  function automatic logic [15:0] exp_word(
    input logic [15:0] last
  );
`ifdef CFG_DAT_PRBS_EN
    return prbs_next(last);
`else
    return last + 16'd1;
`endif
  endfunction

  function automatic logic word_ok(
    input logic [15:0] last,
    input logic [15:0] w
  );
`ifdef CFG_DAT_PRBS_EN
    return (w == exp_word(last)) && (w != 16'h0000);
`else
    return w == exp_word(last);
`endif
  endfunction

endpackage

// File: rtl/cfg_dat_word_filter.sv
// Two-flop synchronizer and stability filter for the CFG_DAT pads.
// Emits a one-cycle acc with the settled word when it differs from last_word.
module cfg_dat_word_filter #(
  parameter int STABLE_CYC = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [15:0] data_in,
  input  logic [15:0] last_word,
  output logic        acc,
  output logic [15:0] word
);
  import cfg_dat_test_pkg::*;

  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam logic [CW-1:0] FULL = CW'(STABLE_CYC);
  localparam logic [CW-1:0] PRE  = CW'(STABLE_CYC - 1);

  logic [15:0]   meta;
  logic [15:0]   sync_w;
  logic [CW-1:0] stab_cnt;

  // meta != sync_w means sync_w changes on this edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta     <= '0;
      sync_w   <= '0;
      stab_cnt <= '0;
      acc      <= 1'b0;
      word     <= '0;
    end else begin
      meta   <= data_in;
      sync_w <= meta;
      acc    <= 1'b0;
      if (!ena || meta != sync_w) begin
        stab_cnt <= '0;
      end else if (stab_cnt != FULL) begin
        stab_cnt <= stab_cnt + 1'b1;
        if (stab_cnt == PRE && sync_w != last_word) begin
          acc  <= 1'b1;
          word <= sync_w;
        end
      end
    end
  end

endmodule

// File: rtl/cfg_dat_test_checker.sv
// CFG_DAT receive checker for GBT test mode: lock, word and error counts.
// Build option CFG_DAT_PRBS_EN selects the PRBS16 expected sequence.
module cfg_dat_test_checker #(
  parameter int STABLE_CYC = 8,
  parameter int LOCK_CNT   = 4,
  parameter int LOSS_CNT   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [15:0] data_in,
  input  logic        clr_cnt,
  output logic        locked,
  output logic        err,
  output logic [31:0] word_cnt,
  output logic [15:0] err_cnt,
  output logic [15:0] last_word
);
  import cfg_dat_test_pkg::*;

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);
  localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_CNT - 1);
  localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_CNT - 1);
  localparam logic [WORD_CNT_W-1:0] WC_MAX = '1;
  localparam logic [ERR_CNT_W-1:0]  EC_MAX = '1;

  state_t        state;
  logic          seeded;
  logic [MW-1:0] match_cnt;
  logic [LW-1:0] miss_cnt;
  logic          acc;
  logic [15:0]   word;
  logic          good;

  cfg_dat_word_filter #(
    .STABLE_CYC(STABLE_CYC)
  ) u_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .data_in  (data_in),
    .last_word(last_word),
    .acc      (acc),
    .word     (word)
  );

  assign good = word_ok(last_word, word);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      seeded    <= 1'b0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
      word_cnt  <= '0;
      err_cnt   <= '0;
      last_word <= '0;
    end else begin
      err <= 1'b0;
      if (!ena) begin
        state  <= S_IDLE;
        locked <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            state     <= S_SEARCH;
            match_cnt <= '0;
            seeded    <= 1'b0;
          end
          S_SEARCH: if (acc) begin
            last_word <= word;
            if (!seeded) begin
              seeded <= 1'b1;
            end else if (good) begin
              match_cnt <= match_cnt + 1'b1;
              if (match_cnt == LOCK_LAST) begin
                state    <= S_LOCKED;
                locked   <= 1'b1;
                miss_cnt <= '0;
              end
            end else begin
              match_cnt <= '0;
            end
          end
          S_LOCKED: if (acc) begin
            last_word <= word;
            if (good) begin
              miss_cnt <= '0;
              if (word_cnt != WC_MAX)
                word_cnt <= word_cnt + 1'b1;
            end else begin
              err <= 1'b1;
              if (err_cnt != EC_MAX)
                err_cnt <= err_cnt + 1'b1;
              if (miss_cnt == LOSS_LAST) begin
                state     <= S_SEARCH;
                locked    <= 1'b0;
                match_cnt <= '0;
                seeded    <= 1'b0;
              end else begin
                miss_cnt <= miss_cnt + 1'b1;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
      // clear overrides any increment on the same edge
      if (clr_cnt) begin
        word_cnt <= '0;
        err_cnt  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cfg_dat_test_checker.sv
// Scoreboard bench for cfg_dat_test_checker with a word-level model.
// Build with CFG_DAT_PRBS_EN to also exercise the PRBS16 stream.
module tb_cfg_dat_test_checker;

  localparam int LOCK_CNT = 4;
  localparam int LOSS_CNT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic        clr_cnt = 1'b0;
  logic [15:0] data_in = '0;
  logic        locked;
  logic        err;
  logic [31:0] word_cnt;
  logic [15:0] err_cnt;
  logic [15:0] last_word;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cfg_dat_test_checker dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .data_in  (data_in),
    .clr_cnt  (clr_cnt),
    .locked   (locked),
    .err      (err),
    .word_cnt (word_cnt),
    .err_cnt  (err_cnt),
    .last_word(last_word)
  );

  typedef struct {
    logic [15:0] w;
    logic        e;
    logic        l;
    logic [31:0] wc;
    logic [15:0] ec;
  } rec_t;

  rec_t q[$];
  rec_t mr;

  // model state: 0 idle, 1 search, 2 locked
  int          m_st = 0;
  bit          m_seed = 0;
  int          m_match = 0;
  int          m_miss = 0;
  logic [15:0] m_last = '0;
  logic [31:0] m_wc = '0;
  logic [15:0] m_ec = '0;
  logic [15:0] pad = '0;
  logic [15:0] seen = '0;

  function automatic logic [15:0] nxt(input logic [15:0] w);
`ifdef CFG_DAT_PRBS_EN
    logic fb;
    fb = w[15] ^ w[13] ^ w[12] ^ w[10];
    return {w[14:0], fb};
`else
    return 16'((32'(w) + 32'd1) % 32'd65536);
`endif
  endfunction

  function automatic bit is_good(input logic [15:0] last, input logic [15:0] w);
`ifdef CFG_DAT_PRBS_EN
    return (w == nxt(last)) && (w != 16'h0000);
`else
    return w == nxt(last);
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_acc(input logic [15:0] w, input bit clr);
    rec_t r;
    bit   g;
    if (clr) begin
      m_wc = '0;
      m_ec = '0;
    end
    if (m_st == 0 || w == m_last) return;
    g = is_good(m_last, w);
    r.e = 1'b0;
    if (m_st == 1) begin
      if (!m_seed) m_seed = 1;
      else if (g) begin
        m_match++;
        if (m_match == LOCK_CNT) begin
          m_st = 2;
          m_miss = 0;
        end
      end else m_match = 0;
    end else begin
      if (g) begin
        if (m_wc != 32'hFFFF_FFFF) m_wc++;
        m_miss = 0;
      end else begin
        r.e = 1'b1;
        if (m_ec != 16'hFFFF) m_ec++;
        m_miss++;
        if (m_miss == LOSS_CNT) begin
          m_st = 1;
          m_match = 0;
          m_seed = 0;
        end
      end
    end
    m_last = w;
    if (clr) begin
      m_wc = '0;
      m_ec = '0;
    end
    r.w  = w;
    r.l  = (m_st == 2);
    r.wc = m_wc;
    r.ec = m_ec;
    q.push_back(r);
  endtask

  // word drives the pads; clr lands on the edge that consumes its acc
  task automatic send(input logic [15:0] w, input int hold, input bit clr);
    @(posedge clk);
    #1 data_in = w;
    if (hold >= 12) begin
      model_acc(w, clr);
      pad = w;
    end
    if (clr) begin
      repeat (10) @(posedge clk);
      #1 clr_cnt = 1'b1;
      @(posedge clk);
      #1 clr_cnt = 1'b0;
      repeat (hold - 11) @(posedge clk);
    end else begin
      repeat (hold) @(posedge clk);
    end
  endtask

  task automatic ena_up();
    @(posedge clk);
    #1 ena = 1'b1;
    m_st = 1;
    m_seed = 0;
    m_match = 0;
    model_acc(pad, 1'b0);
    repeat (15) @(posedge clk);
  endtask

  task automatic ena_down();
    @(posedge clk);
    #1 ena = 1'b0;
    m_st = 0;
    repeat (3) @(posedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      seen = last_word;
    end else begin
      if (last_word !== seen) begin
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_acc got %h want none", last_word);
        end else begin
          mr = q.pop_front();
          chk("acc_word", 32'(last_word), 32'(mr.w));
          chk("acc_err", 32'(err), 32'(mr.e));
          chk("acc_locked", 32'(locked), 32'(mr.l));
          chk("acc_wcnt", word_cnt, mr.wc);
          chk("acc_ecnt", 32'(err_cnt), 32'(mr.ec));
        end
      end else if (err !== 1'b0) begin
        errors++;
        $display("FAIL spurious_err got %b want 0", err);
      end
      seen = last_word;
    end
  end

  initial begin
    logic [15:0] w;
    logic [31:0] wc0;
    int          r;

    // reset with toggling pads
    repeat (6) begin
      @(posedge clk);
      #1 data_in = 16'($urandom);
    end
    @(negedge clk);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_wcnt", word_cnt, 0);
    chk("rst_ecnt", 32'(err_cnt), 0);
    chk("rst_last", 32'(last_word), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) send(16'($urandom), 15, 1'b0);
    send(16'h5A5A, 15, 1'b0);
    @(negedge clk);
    chk("idle_last", 32'(last_word), 0);
    chk("idle_locked", 32'(locked), 0);

    // lock on 0000..0010
    ena_up();
    for (int i = 0; i <= 16; i++) send(16'(i), 20, 1'b0);
`ifndef CFG_DAT_PRBS_EN
    @(negedge clk);
    chk("lock_locked", 32'(locked), 1);
    chk("lock_wcnt", word_cnt, 12);
    chk("lock_ecnt", 32'(err_cnt), 0);
`endif

    // error while locked
    send(16'h0011, 20, 1'b0);
    send(16'h1234, 20, 1'b0);
    send(16'h1235, 20, 1'b0);
    send(16'h1236, 20, 1'b0);
`ifndef CFG_DAT_PRBS_EN
    @(negedge clk);
    chk("err1_ecnt", 32'(err_cnt), 1);
    chk("err1_locked", 32'(locked), 1);
    chk("err1_wcnt", word_cnt, 15);
`endif

    // glitch then loss of lock
    w = pad;
    send(16'hAAAA, 5, 1'b0);
    send(w, 20, 1'b0);
    @(negedge clk);
    chk("glitch_last", 32'(last_word), 32'(m_last));
    send(16'h5000, 20, 1'b0);
    send(16'h7000, 20, 1'b0);
    send(16'h9000, 20, 1'b0);
    @(negedge clk);
    chk("loss_locked", 32'(locked), 0);

    // wrap through FFFF
    for (int i = 16'hFFF9; i <= 16'hFFFD; i++) send(16'(i), 20, 1'b0);
    wc0 = word_cnt;
    send(16'hFFFE, 20, 1'b0);
    send(16'hFFFF, 20, 1'b0);
    send(16'h0000, 20, 1'b0);
    send(16'h0001, 20, 1'b0);
`ifndef CFG_DAT_PRBS_EN
    @(negedge clk);
    chk("wrap_wcnt", word_cnt, wc0 + 32'd4);
    chk("wrap_locked", 32'(locked), 1);
`endif

    // ENA drop holds counters
    ena_down();
    @(negedge clk);
    chk("ena_locked", 32'(locked), 0);
    chk("ena_wcnt", word_cnt, m_wc);
    chk("ena_ecnt", 32'(err_cnt), 32'(m_ec));
    chk("ena_last", 32'(last_word), 32'(m_last));
    send(16'h4444, 15, 1'b0);
    @(negedge clk);
    chk("ena_idle_last", 32'(last_word), 32'(m_last));
    ena_up();
    for (int i = 16'h4445; i <= 16'h4449; i++) send(16'(i), 20, 1'b0);
    send(16'h0BAD, 20, 1'b1);
    @(negedge clk);
    chk("clr_ecnt", 32'(err_cnt), 0);
    chk("clr_wcnt", word_cnt, 0);

    // randomized stream
    for (int n = 0; n < 150; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6) w = nxt(m_last);
      else if (r < 8) w = 16'($urandom);
      else if (r == 8) begin
        w = pad;
        send(16'($urandom), int'($urandom_range(2, 5)), 1'b0);
      end else w = m_last;
      send(w, int'($urandom_range(12, 25)), ($urandom_range(0, 15) == 0));
    end

`ifdef CFG_DAT_PRBS_EN
    ena_down();
    ena_up();
    w = 16'hACE1;
    for (int i = 0; i < 8; i++) begin
      send(w, 20, 1'b0);
      w = nxt(w);
    end
    @(negedge clk);
    chk("prbs_locked", 32'(locked), 1);
    send(16'h0000, 20, 1'b0);
    @(negedge clk);
    chk("prbs_zero_last", 32'(last_word), 0);
`endif

    chk("sb_empty", 32'(q.size()), 0);
    chk("final_wcnt", word_cnt, m_wc);
    chk("final_ecnt", 32'(err_cnt), 32'(m_ec));

    // asynchronous reset mid-stream
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_locked", 32'(locked), 0);
    chk("arst_wcnt", word_cnt, 0);
    chk("arst_ecnt", 32'(err_cnt), 0);
    chk("arst_last", 32'(last_word), 0);
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
